// File: rtl/apb_pkg.sv
// Shared types and constants for the APB register completer and its helpers.
// Everything bus-related that more than one file needs lives here.
package apb_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;
    localparam int REG_STRIDE = 4;
    localparam int WAIT_W     = 4;

    typedef enum logic {
        ST_IDLE,
        ST_ACCESS
    } apb_slv_state_t;

    typedef enum logic [1:0] {
        HIT_MISS,
        HIT_RW,
        HIT_CNT
    } apb_hit_t;

    // The read-only transfer counter sits directly after the last RW register.
    function automatic int cnt_offset(input int num_regs);
        return REG_STRIDE * num_regs;
    endfunction

endpackage

// File: rtl/apb_reg_slave_if.sv
// APB completer-side signal bundle; the master modport drives the request,
// the slave modport drives the response.
interface apb_reg_slave_if
    import apb_pkg::*;
#(
    parameter int ADDR_W = APB_ADDR_W,
    parameter int DATA_W = APB_DATA_W
);
    logic              PSEL_S_INF;
    logic              PENABLE_S_INF;
    logic              PWRITE_S_INF;
    logic [ADDR_W-1:0] PADDR_S_INF;
    logic [DATA_W-1:0] PWDATA_S_INF;
    logic              PREADY_S_INF;
    logic [DATA_W-1:0] PRDATA_S_INF;
    logic              PSLVERR_S_INF;

    modport master (
        output PSEL_S_INF, PENABLE_S_INF, PWRITE_S_INF, PADDR_S_INF, PWDATA_S_INF,
        input  PREADY_S_INF, PRDATA_S_INF, PSLVERR_S_INF
    );

    modport slave (
        input  PSEL_S_INF, PENABLE_S_INF, PWRITE_S_INF, PADDR_S_INF, PWDATA_S_INF,
        output PREADY_S_INF, PRDATA_S_INF, PSLVERR_S_INF
    );

endinterface

// File: rtl/apb_wait_ctr.sv
// Wait-state counter: load a count, decrement toward zero, flag when empty.
// Generic enough to pace any APB completer.
module apb_wait_ctr #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/apb_reg_slave.sv
// APB completer with NUM_REGS RW registers, a read-only completed-transfer
// counter, programmable wait states and PSLVERR on bad address or illegal write.
module apb_reg_slave
    import apb_pkg::*;
#(
    parameter int                ADDR_W      = APB_ADDR_W,
    parameter int                DATA_W      = APB_DATA_W,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 'h1000,
    parameter int                NUM_REGS    = 4,
    parameter int                WAIT_CYCLES = 2
) (
    input  logic          PCLK,
    input  logic          PRESET_N,
    apb_reg_slave_if.slave bus
);

    localparam int                IDX_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_W-1:0] RW_SPAN = ADDR_W'(cnt_offset(NUM_REGS));

    apb_slv_state_t state, state_nxt;

    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              write_q;
    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [DATA_W-1:0] xfer_cnt;

    logic              setup, ctr_load, ctr_dec, ctr_zero, done, err;
    logic [ADDR_W-1:0] offset;
    logic [IDX_W-1:0]  idx;
    apb_hit_t          hit;
    logic [DATA_W-1:0] rd_val;

    assign setup = bus.PSEL_S_INF && !bus.PENABLE_S_INF;

    apb_wait_ctr #(.W(WAIT_W)) u_wait_ctr (
        .clk      (PCLK),
        .rst_n    (PRESET_N),
        .load     (ctr_load),
        .dec      (ctr_dec),
        .load_val (WAIT_W'(WAIT_CYCLES)),
        .zero     (ctr_zero)
    );

    always_ff @(posedge PCLK or negedge PRESET_N) begin
        if (!PRESET_N) state <= ST_IDLE;
        else           state <= state_nxt;
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (setup) state_nxt = ST_ACCESS;
            ST_ACCESS: begin
                if (!bus.PSEL_S_INF)                         state_nxt = ST_IDLE;
                else if (bus.PENABLE_S_INF && ctr_zero)      state_nxt = ST_IDLE;
            end
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        ctr_load = 1'b0;
        ctr_dec  = 1'b0;
        done     = 1'b0;
        case (state)
            ST_IDLE:   ctr_load = setup;
            ST_ACCESS: begin
                if (bus.PSEL_S_INF && bus.PENABLE_S_INF) begin
                    done    = ctr_zero;
                    ctr_dec = !ctr_zero;
                end
            end
            default: ;
        endcase
    end

    // Request is frozen at setup; later bus changes cannot alter the transfer.
    always_ff @(posedge PCLK or negedge PRESET_N) begin
        if (!PRESET_N) begin
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
        end else if ((state == ST_IDLE) && setup) begin
            addr_q  <= bus.PADDR_S_INF;
            wdata_q <= bus.PWDATA_S_INF;
            write_q <= bus.PWRITE_S_INF;
        end
    end

    assign offset = addr_q - BASE_ADDR;
    assign idx    = offset[IDX_W+1:2];

    always_comb begin
        hit = HIT_MISS;
        if ((addr_q >= BASE_ADDR) && (offset < RW_SPAN) && (addr_q[1:0] == 2'b00))
            hit = HIT_RW;
        else if (offset == RW_SPAN)
            hit = HIT_CNT;
    end

    assign err = (hit == HIT_MISS) || ((hit == HIT_CNT) && write_q);

    always_comb begin
        rd_val = '0;
        case (hit)
            HIT_RW:  rd_val = regs[idx];
            HIT_CNT: rd_val = xfer_cnt;
            default: rd_val = '0;
        endcase
    end

    // NOTE: the register array is reset explicitly because software expects zeros after reset.
    always_ff @(posedge PCLK or negedge PRESET_N) begin
        if (!PRESET_N) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            xfer_cnt <= '0;
        end else if (done && !err) begin
            if ((hit == HIT_RW) && write_q) regs[idx] <= wdata_q;
            xfer_cnt <= xfer_cnt + DATA_W'(1);
        end
    end

    always_comb begin
        bus.PREADY_S_INF  = done;
        bus.PSLVERR_S_INF = done && err;
        bus.PRDATA_S_INF  = (done && !err && !write_q) ? rd_val : '0;
    end

endmodule

// File: tb/tb_apb_reg_slave.sv
// Randomized bench for apb_reg_slave, checked against an array-based model
// of the register map, plus directed abort, reset, wrap and zero-wait cases.
module tb_apb_reg_slave;

    localparam int          W    = 2;
    localparam int          NR   = 4;
    localparam logic [31:0] BASE = 32'h1000;
    localparam logic [31:0] CNTA = BASE + 32'(4 * NR);

    logic PCLK = 1'b0;
    logic PRESET_N;
    always #5 PCLK = ~PCLK;

    apb_reg_slave_if bus ();
    apb_reg_slave_if bus0 ();

    apb_reg_slave #(.BASE_ADDR(BASE), .NUM_REGS(NR), .WAIT_CYCLES(W)) dut (
        .PCLK (PCLK), .PRESET_N (PRESET_N), .bus (bus)
    );
    apb_reg_slave #(.BASE_ADDR(BASE), .NUM_REGS(NR), .WAIT_CYCLES(0)) dut0 (
        .PCLK (PCLK), .PRESET_N (PRESET_N), .bus (bus0)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] regs_m [NR];
    logic [31:0] cnt_m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) regs_m[i] = '0;
        cnt_m = '0;
    endtask

    // Register map rules expressed with plain integer arithmetic.
    task automatic model_xfer(input logic wr, input logic [31:0] a, input logic [31:0] d,
                              output logic [31:0] rdata, output logic err);
        longint off;
        off   = longint'(a) - longint'(BASE);
        rdata = '0;
        err   = 1'b1;
        if (off >= 0 && off < 4 * NR && off % 4 == 0) begin
            err = 1'b0;
            if (wr) regs_m[off / 4] = d;
            else    rdata = regs_m[off / 4];
        end else if (off == 4 * NR) begin
            err = wr;
            if (!wr) rdata = cnt_m;
        end
        if (!err) cnt_m = cnt_m + 32'd1;
    endtask

    task automatic drive(input int which, input logic sel, input logic en, input logic wr,
                         input logic [31:0] a, input logic [31:0] d);
        if (which == 0) begin
            bus.PSEL_S_INF = sel;  bus.PENABLE_S_INF = en;  bus.PWRITE_S_INF = wr;
            bus.PADDR_S_INF = a;   bus.PWDATA_S_INF = d;
        end else begin
            bus0.PSEL_S_INF = sel; bus0.PENABLE_S_INF = en; bus0.PWRITE_S_INF = wr;
            bus0.PADDR_S_INF = a;  bus0.PWDATA_S_INF = d;
        end
    endtask

    function automatic logic rdy(input int which);
        return (which == 0) ? bus.PREADY_S_INF : bus0.PREADY_S_INF;
    endfunction

    // Starts and ends just after a rising edge, so calls chain back-to-back.
    task automatic xfer(input int which, input logic wr, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rdata, output logic err, output int acc);
        drive(which, 1'b1, 1'b0, wr, a, d);
        @(posedge PCLK); #1;
        drive(which, 1'b1, 1'b1, wr, a, d);
        acc = 0; rdata = '0; err = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge PCLK);
            acc++;
            if (rdy(which)) begin
                rdata = (which == 0) ? bus.PRDATA_S_INF  : bus0.PRDATA_S_INF;
                err   = (which == 0) ? bus.PSLVERR_S_INF : bus0.PSLVERR_S_INF;
                break;
            end
            @(posedge PCLK); #1;
        end
        @(posedge PCLK); #1;
        drive(which, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic do_xfer(input string tag, input logic wr, input logic [31:0] a,
                           input logic [31:0] d, output logic [31:0] got);
        logic [31:0] rd, exp_rd;
        logic        er, exp_er;
        int          acc;
        xfer(0, wr, a, d, rd, er, acc);
        model_xfer(wr, a, d, exp_rd, exp_er);
        check({tag, "_rdata"}, rd, exp_rd);
        check({tag, "_err"}, 32'(er), 32'(exp_er));
        check({tag, "_lat"}, 32'(acc), 32'(W + 1));
        got = rd;
    endtask

    // Response must stay quiet unless an access phase is completing.
    always @(negedge PCLK) begin
        if (PRESET_N === 1'b1) begin
            check("ready_outside_access",
                  32'(bus.PREADY_S_INF & ~(bus.PSEL_S_INF & bus.PENABLE_S_INF)), 32'd0);
            check("rdata_without_ready", bus.PRDATA_S_INF & {32{~bus.PREADY_S_INF}}, 32'd0);
            check("slverr_without_ready", 32'(bus.PSLVERR_S_INF & ~bus.PREADY_S_INF), 32'd0);
        end
    end

    task automatic pulse_reset();
        PRESET_N = 1'b0;
        drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, 1'b0, '0, '0);
        repeat (2) @(posedge PCLK);
        #1 PRESET_N = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [31:0] r, a, d;
        logic        wr, er;
        int          acc;

        PRESET_N = 1'b0;
        drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, 1'b0, '0, '0);
        model_reset();
        repeat (2) @(posedge PCLK);
        #1;
        check("rst_ready",  32'(bus.PREADY_S_INF),  32'd0);
        check("rst_slverr", 32'(bus.PSLVERR_S_INF), 32'd0);
        check("rst_rdata",  bus.PRDATA_S_INF,       32'd0);
        PRESET_N = 1'b1;

        // 1: first read after reset
        do_xfer("t1_rd", 1'b0, BASE, '0, r);

        // 2: write/read/counter from a fresh reset
        pulse_reset();
        do_xfer("t2_wr", 1'b1, BASE + 32'h4, 32'hDEAD_BEEF, r);
        do_xfer("t2_rd", 1'b0, BASE + 32'h4, '0, r);
        check("t2_value", r, 32'hDEAD_BEEF);
        do_xfer("t2_cnt", 1'b0, CNTA, '0, r);
        check("t2_cnt_value", r, 32'd2);

        // 3: back-to-back read-modify-write loop
        for (int i = 0; i < 10; i++) begin
            do_xfer("t3_rd", 1'b0, BASE, '0, r);
            do_xfer("t3_wr", 1'b1, BASE, r + 32'd1, r);
        end
        do_xfer("t3_final", 1'b0, BASE, '0, r);
        check("t3_final_value", r, 32'd10);

        // 4: out-of-range, misaligned and counter-write errors
        do_xfer("t4_oor",   1'b0, BASE + 32'h20, '0, r);
        do_xfer("t4_misal", 1'b0, BASE + 32'h2,  '0, r);
        do_xfer("t4_cntwr", 1'b1, CNTA, 32'h1234_5678, r);
        do_xfer("t4_cnt",   1'b0, CNTA, '0, r);
        do_xfer("t4_reg0",  1'b0, BASE, '0, r);

        // randomized mix of hits, errors and counter reads
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 5))
                0, 1:    a = BASE + 32'(4 * $urandom_range(0, NR - 1));
                2:       a = CNTA;
                3:       a = BASE + 32'(4 * $urandom_range(0, NR - 1)) + 32'($urandom_range(1, 3));
                4:       a = CNTA + 32'(4 * $urandom_range(1, 8));
                default: a = BASE - 32'(4 * $urandom_range(1, 4));
            endcase
            wr = 1'($urandom_range(0, 1));
            d  = $urandom;
            do_xfer("rnd", wr, a, d, r);
        end

        // 5: master abort during the first wait cycle of a write
        drive(0, 1'b1, 1'b0, 1'b1, BASE + 32'h8, 32'h5);
        @(posedge PCLK); #1;
        drive(0, 1'b1, 1'b1, 1'b1, BASE + 32'h8, 32'h5);
        @(negedge PCLK);
        check("t5_no_ready", 32'(bus.PREADY_S_INF), 32'd0);
        @(posedge PCLK); #1;
        drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
        repeat (3) @(posedge PCLK);
        #1;
        do_xfer("t5_rd",  1'b0, BASE + 32'h8, '0, r);
        do_xfer("t5_cnt", 1'b0, CNTA, '0, r);

        // 8: counter wrap, injected near the top of its range
        force dut.xfer_cnt = 32'hFFFF_FFFF;
        #2 release dut.xfer_cnt;
        cnt_m = 32'hFFFF_FFFF;
        do_xfer("t8_good", 1'b0, BASE, '0, r);
        do_xfer("t8_cnt",  1'b0, CNTA, '0, r);
        check("t8_wrapped", r, 32'd0);

        // 6: reset in the completion cycle of a read
        do_xfer("t6_wr", 1'b1, BASE, 32'd7, r);
        drive(0, 1'b1, 1'b0, 1'b0, BASE, '0);
        @(posedge PCLK); #1;
        drive(0, 1'b1, 1'b1, 1'b0, BASE, '0);
        repeat (W) @(posedge PCLK);
        @(negedge PCLK);
        check("t6_pre_ready", 32'(bus.PREADY_S_INF), 32'd1);
        check("t6_pre_rdata", bus.PRDATA_S_INF, 32'd7);
        #1 PRESET_N = 1'b0;
        #1;
        check("t6_rst_ready",  32'(bus.PREADY_S_INF),  32'd0);
        check("t6_rst_slverr", 32'(bus.PSLVERR_S_INF), 32'd0);
        check("t6_rst_rdata",  bus.PRDATA_S_INF,       32'd0);
        drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
        @(posedge PCLK); #1 PRESET_N = 1'b1;
        model_reset();
        do_xfer("t6_rd", 1'b0, BASE, '0, r);
        check("t6_cleared", r, 32'd0);

        // 7: zero wait states
        xfer(1, 1'b1, BASE + 32'h4, 32'hA5A5_0F0F, r, er, acc);
        check("t7_wr_lat", 32'(acc), 32'd1);
        check("t7_wr_err", 32'(er),  32'd0);
        xfer(1, 1'b0, BASE + 32'h4, '0, r, er, acc);
        check("t7_rd_lat",   32'(acc), 32'd1);
        check("t7_rd_value", r,        32'hA5A5_0F0F);
        xfer(1, 1'b0, BASE + 32'h40, '0, r, er, acc);
        check("t7_miss_err",   32'(er), 32'd1);
        check("t7_miss_rdata", r,       32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_reg_slave.md
Name: apb_reg_slave

Overview:
- APB completer (slave) that answers the add-master's transfers.
- Holds NUM_REGS read/write 32-bit registers plus one read-only transfer counter.
- Inserts a programmable number of wait states before asserting PREADY.
- Flags bad addresses and illegal writes with PSLVERR; sits on the APB bus opposite apb_add_master.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- BASE_ADDR, 32'h1000, address of register 0.
- NUM_REGS, 4, number of RW registers (1..16), at BASE_ADDR + 4*i.
- WAIT_CYCLES, 2, wait states inserted per transfer (0..15).

Ports:
- Interface: one clock; reset is asynchronous and active-low. Ports are PCLK and PRESET_N.
- PCLK  input  1  bus clock, all state on rising edge
- PRESET_N  input  1  async active-low reset
- PSEL_S_INF  input  1  slave select
- PENABLE_S_INF  input  1  access-phase indicator
- PWRITE_S_INF  input  1  1 = write, 0 = read
- PADDR_S_INF  input  ADDR_W  byte address
- PWDATA_S_INF  input  DATA_W  write data
- PREADY_S_INF  output  1  transfer complete
- PRDATA_S_INF  output  DATA_W  read data, valid only with PREADY on a read
- PSLVERR_S_INF  output  1  error response, valid only with PREADY

Behaviour:
- Reset (async, any cycle, including mid-transfer):
  - state = ST_IDLE, wait counter = 0.
  - All RW registers = 0; XFER_CNT = 0.
  - PREADY, PSLVERR, PRDATA = 0.
  - An interrupted transfer has no side effect.
- FSM, two states (typedef in package):
  - ST_IDLE: outputs 0. On PSEL=1 && PENABLE=0 (setup phase):
    - Capture PADDR, PWRITE, PWDATA.
    - Load wait counter = WAIT_CYCLES.
    - Go to ST_ACCESS.
  - ST_ACCESS, while PSEL=1 && PENABLE=1:
    - Counter != 0: PREADY = 0, decrement, stay.
    - Counter == 0: PREADY = 1 combinationally, perform the transfer, return to ST_IDLE.
    - The next cycle may be a new setup phase; it is decoded in ST_IDLE, so back-to-back transfers are supported.
  - ST_ACCESS with PSEL=0 (master abort): return to ST_IDLE, no write, no count, PREADY stays 0.
- Latency: first access cycle + WAIT_CYCLES.
  - PREADY is high in access cycle WAIT_CYCLES+1.
  - A full transfer is 2+WAIT_CYCLES PCLK cycles.
- Decode, using the captured address:
  - RW hit: address in [BASE_ADDR, BASE_ADDR+4*NUM_REGS) and addr[1:0] = 0; index = (addr - BASE_ADDR) >> 2.
  - Counter hit: address = BASE_ADDR + 4*NUM_REGS.
  - Anything else (including misaligned) is a miss.
- Completion cycle (PREADY = 1):
  - RW write: register <= captured PWDATA at the clock edge; PSLVERR = 0.
  - RW read: PRDATA = register value; PSLVERR = 0.
  - Counter read: PRDATA = XFER_CNT (value before this transfer's increment); PSLVERR = 0.
  - Counter write: PSLVERR = 1, no state change.
  - Miss: PSLVERR = 1, PRDATA = 0, no write.
- PRDATA = 0 whenever PREADY = 0 or the transfer is a write.
- XFER_CNT increments by 1 on every completion with PSLVERR = 0. It wraps 32'hFFFF_FFFF -> 0.
- Address, write data and direction changes after setup are ignored; the captured copies are used. A protocol violation does not corrupt state.

Decomposition:
- Package apb_pkg:
  - apb_slv_state_t enum {ST_IDLE, ST_ACCESS}.
  - APB_ADDR_W = 32, APB_DATA_W = 32.
  - Localparams for the counter offset.
- One sub-module is natural: apb_wait_ctr (load / decrement / zero-flag counter, width 4), reusable by other slaves.
- The register bank stays inline.

Test Plan:
1. Reset, then read 0x1000, WAIT_CYCLES=2 -> PREADY high on the 3rd access cycle, PRDATA = 0, PSLVERR = 0.
2. Write 0x1004 <= 32'hDEAD_BEEF, then read 0x1004 -> PRDATA = 32'hDEAD_BEEF, both PSLVERR = 0, XFER_CNT read at 0x1010 returns 2.
3. Back-to-back add-master loop (read 0x1000, write read+1, ten iterations) -> final read of 0x1000 = 10; PREADY never high outside ST_ACCESS.
4. Read 0x1020, read 0x1002 and write 0x1010 -> each gives PREADY with PSLVERR = 1, PRDATA = 0; registers and XFER_CNT unchanged.
5. Deassert PSEL in the 1st wait cycle of a write of 0x5 to 0x1008 -> no PREADY, 0x1008 stays 0; the next transfer completes normally.
6. Assert PRESET_N = 0 mid-access after writing 0x1000 = 7 -> all outputs 0 immediately; read 0x1000 returns 0.
7. With WAIT_CYCLES=0 -> PREADY in the first access cycle.
8. XFER_CNT forced to 32'hFFFF_FFFF (bench-injected) followed by one good transfer -> the counter reads 0.
